// File: rtl/d8m_i2c_pkg.sv
// Shared constants, command decode and FSM encodings for the D8M I2C byte engine.
package d8m_i2c_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_CMD  = 2'd1;

    localparam int unsigned CMD_START = 0;
    localparam int unsigned CMD_STOP  = 1;
    localparam int unsigned CMD_WRITE = 2;
    localparam int unsigned CMD_READ  = 3;
    localparam int unsigned CMD_NACK  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BYTE  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef struct packed {
        logic start;
        logic stop;
        logic write;
        logic read;
        logic nack;
    } cmd_t;

    // Decode a CMD word; WRITE takes priority over READ.
    function automatic cmd_t decode_cmd(input logic [4:0] bits);
        cmd_t c;
        c       = '0;
        c.start = bits[CMD_START];
        c.stop  = bits[CMD_STOP];
        c.write = bits[CMD_WRITE];
        c.read  = bits[CMD_READ] & ~bits[CMD_WRITE];
        c.nack  = bits[CMD_NACK];
        return c;
    endfunction

    // A command does something only if it requests at least one bus phase.
    function automatic logic cmd_valid(input cmd_t c);
        return c.start | c.stop | c.write | c.read;
    endfunction

    // First phase of a freshly accepted command.
    function automatic state_t first_state(input cmd_t c);
        if (c.start)                 return ST_START;
        else if (c.write || c.read)  return ST_BYTE;
        else                         return ST_STOP;
    endfunction

endpackage

// File: rtl/d8m_i2c_tick_gen.sv
// Quarter-period tick generator: one tick every CLK_DIV clocks, frozen while i_hold.
module d8m_i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick_c = (r_cnt == CNT_MAX) && !i_hold;

    // Count clocks within the current quarter; restart on clear or tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick_c) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/d8m_i2c_master.sv
// Avalon-MM I2C master byte engine: START, 8 data bits, ACK/NACK, STOP on open-drain pins.
module d8m_i2c_master
    import d8m_i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    inout  wire               i2c_scl,
    inout  wire               i2c_sda
);

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_phase;
    logic [1:0]        w_phase_nx;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_nx;
    logic [BYTE_W-1:0] r_shift;
    logic [BYTE_W-1:0] w_shift_nx;
    logic [BYTE_W-1:0] r_txdata;
    logic [BYTE_W-1:0] r_rxdata;
    logic [BYTE_W-1:0] w_rxdata_nx;
    logic              r_ack_err;
    logic              w_ack_err_nx;
    cmd_t              r_cmd;
    cmd_t              w_cmd_nx;
    cmd_t              w_wcmd;
    logic              r_scl_low;
    logic              w_scl_low_nx;
    logic              r_sda_low;
    logic              w_sda_low_nx;
    logic [DATA_W-1:0] r_readdata;
    logic [DATA_W-1:0] w_rd_mux;

    logic w_wr_en;
    logic w_busy;
    logic w_accept;
    logic w_tick;
    logic w_hold;
    logic w_adv;
    logic w_scl_in;
    logic w_sda_in;
    logic w_unused;

    assign w_unused = ^writedata[DATA_W-1:BYTE_W];

    assign i2c_scl  = r_scl_low ? 1'b0 : 1'bz;
    assign i2c_sda  = r_sda_low ? 1'b0 : 1'bz;
    assign w_scl_in = i2c_scl;
    assign w_sda_in = i2c_sda;
    assign readdata = r_readdata;

    assign w_wr_en  = chipselect && !write_n;
    assign w_busy   = (r_state != ST_IDLE);
    assign w_wcmd   = decode_cmd(writedata[4:0]);
    assign w_accept = w_wr_en && (address == ADDR_CMD) && !w_busy && cmd_valid(w_wcmd);

    // A slave holding SCL low after we release it stretches the q1 quarter.
    assign w_hold   = w_busy && (r_phase == Q1) && !r_scl_low && !w_scl_in;
    assign w_adv    = w_busy && w_tick;

    d8m_i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_accept),
        .i_hold   (w_hold),
        .o_tick_c (w_tick)
    );

    // Next-state, datapath and line-drive computation for the quarter being entered.
    always_comb begin
        w_state_nx   = r_state;
        w_phase_nx   = r_phase;
        w_bit_nx     = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_cmd_nx     = r_cmd;
        w_ack_err_nx = r_ack_err;
        w_rxdata_nx  = r_rxdata;
        w_scl_low_nx = r_scl_low;
        w_sda_low_nx = r_sda_low;

        if (w_accept) begin
            w_cmd_nx     = w_wcmd;
            w_state_nx   = first_state(w_wcmd);
            w_phase_nx   = Q0;
            w_bit_nx     = '0;
            w_shift_nx   = r_txdata;
            w_ack_err_nx = 1'b0;
        end else if (w_adv) begin
            w_phase_nx = r_phase + 2'd1;
            if (r_phase == Q2) begin
                if (r_state == ST_BYTE) begin
                    w_shift_nx = {r_shift[BYTE_W-2:0], w_sda_in};
                end
                if (r_state == ST_ACK && r_cmd.write) begin
                    w_ack_err_nx = w_sda_in;
                end
            end
            if (r_phase == Q3) begin
                case (r_state)
                    ST_START: begin
                        if (r_cmd.write || r_cmd.read) w_state_nx = ST_BYTE;
                        else if (r_cmd.stop)           w_state_nx = ST_STOP;
                        else                           w_state_nx = ST_IDLE;
                    end
                    ST_BYTE: begin
                        if (r_bit_cnt == 3'd7) w_state_nx = ST_ACK;
                        else                   w_bit_nx   = r_bit_cnt + 3'd1;
                    end
                    ST_ACK: begin
                        w_rxdata_nx = r_shift;
                        w_state_nx  = r_cmd.stop ? ST_STOP : ST_IDLE;
                    end
                    default: w_state_nx = ST_IDLE;
                endcase
            end
        end

        // SDA only changes at q0 of a bit so it is stable across the SCL high time.
        if (w_accept || w_adv) begin
            case (w_state_nx)
                ST_START: begin
                    w_scl_low_nx = (w_phase_nx == Q3);
                    w_sda_low_nx = (w_phase_nx >= Q2);
                end
                ST_BYTE: begin
                    w_scl_low_nx = (w_phase_nx == Q0) || (w_phase_nx == Q3);
                    if (w_phase_nx == Q0) begin
                        w_sda_low_nx = w_cmd_nx.write && !w_shift_nx[BYTE_W-1];
                    end
                end
                ST_ACK: begin
                    w_scl_low_nx = (w_phase_nx == Q0) || (w_phase_nx == Q3);
                    if (w_phase_nx == Q0) begin
                        w_sda_low_nx = w_cmd_nx.read && !w_cmd_nx.nack;
                    end
                end
                ST_STOP: begin
                    w_scl_low_nx = (w_phase_nx == Q0);
                    w_sda_low_nx = (w_phase_nx <= Q1);
                end
                default: begin
                    // Between commands without STOP, keep SCL as left so the bus stays owned.
                    w_sda_low_nx = 1'b0;
                end
            endcase
        end
    end

    // Register read mux.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux = {24'b0, r_rxdata};
            ADDR_CMD:  w_rd_mux = {30'b0, r_ack_err, w_busy};
            default:   w_rd_mux = '0;
        endcase
    end

    // State, datapath and open-drain drive registers; reset releases both lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_phase    <= Q0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_txdata   <= '0;
            r_rxdata   <= '0;
            r_ack_err  <= 1'b0;
            r_cmd      <= '0;
            r_scl_low  <= 1'b0;
            r_sda_low  <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_phase    <= w_phase_nx;
            r_bit_cnt  <= w_bit_nx;
            r_shift    <= w_shift_nx;
            r_rxdata   <= w_rxdata_nx;
            r_ack_err  <= w_ack_err_nx;
            r_cmd      <= w_cmd_nx;
            r_scl_low  <= w_scl_low_nx;
            r_sda_low  <= w_sda_low_nx;
            r_readdata <= w_rd_mux;
            if (w_wr_en && (address == ADDR_DATA) && !w_busy) begin
                r_txdata <= writedata[BYTE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_d8m_i2c_master.sv
// Self-checking bench for d8m_i2c_master with a behavioural I2C slave and SDA scoreboard.
module tb_d8m_i2c_master;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    wire  [31:0] readdata;
    wire         scl_w;
    wire         sda_w;

    logic slv_scl_low = 1'b0;
    logic slv_sda_low = 1'b0;

    pullup (scl_w);
    pullup (sda_w);
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

    d8m_i2c_master #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .i2c_scl    (scl_w),
        .i2c_sda    (sda_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of SDA values expected at each SCL rise of a byte+ACK.
    logic exp_bits[$];

    // Behavioural slave state.
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    int         bitcnt = 0;
    int         falls = 0;
    bit         in_xfer = 0;
    int         starts = 0;
    int         stops = 0;
    bit         chk_en = 1;
    bit         slv_ack = 1;
    bit         slv_read_mode = 0;
    logic [7:0] slv_rd_byte = 8'h00;
    int         stretch_fall = -1;
    int         stretch_cnt = 0;

    // Slave: detect START/STOP, check SDA at SCL rises, drive ACK/read data, stretch SCL.
    always @(negedge clk) begin
        if (stretch_cnt > 0) begin
            stretch_cnt--;
            if (stretch_cnt == 0) slv_scl_low = 1'b0;
        end
        if (p_scl && scl_w && p_sda && !sda_w) begin
            starts++;
            in_xfer = 1;
            bitcnt  = 0;
            falls   = 0;
        end else if (p_scl && scl_w && !p_sda && sda_w) begin
            stops++;
            in_xfer     = 0;
            slv_sda_low = 1'b0;
        end else if (in_xfer && !p_scl && scl_w) begin
            if (chk_en && bitcnt < 9) begin
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sda_rise_unexpected: got rise %0d expected none", bitcnt);
                end else begin
                    check($sformatf("sda_rise%0d", bitcnt), {31'b0, sda_w}, {31'b0, exp_bits.pop_front()});
                end
            end
            bitcnt++;
        end else if (in_xfer && p_scl && !scl_w) begin
            falls++;
            if (slv_read_mode) slv_sda_low = (bitcnt < 8) ? !slv_rd_byte[3'(7 - bitcnt)] : 1'b0;
            else               slv_sda_low = (bitcnt == 8) && slv_ack;
            if (falls == stretch_fall) begin
                slv_scl_low = 1'b1;
                stretch_cnt = 2 * DIV + 20;
            end
        end
        p_scl = scl_w;
        p_sda = sda_w;
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        @(negedge clk);
        d = readdata;
    endtask

    // Issue a command and count cycles with busy visible on STATUS.
    task automatic run_cmd(input logic [7:0] cmd, output int n, output bit done);
        n    = 0;
        done = 0;
        bus_write(2'd1, {24'b0, cmd});
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (readdata[0]) n++;
            else if (n > 0) begin
                done = 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  tx;
        logic [7:0]  cmd;
        bit          ack;
        int          stretch_fall;
        logic [31:0] exp_status;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic push_byte(input logic [7:0] b, input logic ninth);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        exp_bits.push_back(ninth);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          n;
        bit          done;
        logic [31:0] st;
        bus_write(2'd0, {24'b0, v.tx});
        slv_ack       = v.ack;
        slv_read_mode = 0;
        stretch_fall  = v.stretch_fall;
        push_byte(v.tx, v.ack ? 1'b0 : 1'b1);
        starts = 0;
        stops  = 0;
        run_cmd(v.cmd, n, done);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_busy_cycles"}, n, v.exp_busy);
        check({tag, "_sb_drained"}, exp_bits.size(), 0);
        check({tag, "_starts"}, starts, 1);
        check({tag, "_stops"}, stops, 1);
        read_reg(2'd1, st);
        check({tag, "_status"}, st, v.exp_status);
        check({tag, "_lines_idle"}, {30'b0, scl_w, sda_w}, 32'd3);
        stretch_fall = -1;
        exp_bits.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          n;
        bit          done;

        vecs[0] = '{tx: 8'hA5, cmd: 8'h07, ack: 1, stretch_fall: -1, exp_status: 32'h0, exp_busy: 44 * DIV};
        vecs[1] = '{tx: 8'hA5, cmd: 8'h07, ack: 0, stretch_fall: -1, exp_status: 32'h2, exp_busy: 44 * DIV};
        vecs[2] = '{tx: 8'h00, cmd: 8'h07, ack: 1, stretch_fall: -1, exp_status: 32'h0, exp_busy: 44 * DIV};
        vecs[3] = '{tx: 8'hFF, cmd: 8'h07, ack: 0, stretch_fall: -1, exp_status: 32'h2, exp_busy: 44 * DIV};
        vecs[4] = '{tx: 8'hC3, cmd: 8'h07, ack: 1, stretch_fall: 4,  exp_status: 32'h0, exp_busy: 44 * DIV + 20};
        vecs[5] = '{tx: 8'h6E, cmd: 8'h0F, ack: 1, stretch_fall: -1, exp_status: 32'h0, exp_busy: 44 * DIV};

        reset_n    = 1'b0;
        address    = 2'd1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_lines", {30'b0, scl_w, sda_w}, 32'd3);
        check("rst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        read_reg(2'd1, rd);
        check("rst_status", rd, 32'h0);
        read_reg(2'd0, rd);
        check("rst_rxdata", rd, 32'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Read: START alone, then READ|NACK|STOP; slave returns 0x3C.
        slv_read_mode = 1;
        slv_rd_byte   = 8'h3C;
        starts = 0;
        stops  = 0;
        run_cmd(8'h01, n, done);
        check("rd_start_busy", n, 4 * DIV);
        push_byte(8'h3C, 1'b1);
        run_cmd(8'h1A, n, done);
        check("rd_done", {31'b0, done}, 32'd1);
        check("rd_busy", n, 40 * DIV);
        check("rd_sb_drained", exp_bits.size(), 0);
        check("rd_starts", starts, 1);
        check("rd_stops", stops, 1);
        read_reg(2'd0, rd);
        check("rd_rxdata", rd, 32'h3C);
        read_reg(2'd1, rd);
        check("rd_status", rd, 32'h0);
        slv_read_mode = 0;
        exp_bits.delete();

        // Writes while busy must not touch the byte in flight or the stored TXDATA.
        bus_write(2'd0, 32'h96);
        slv_ack = 1;
        push_byte(8'h96, 1'b0);
        starts = 0;
        stops  = 0;
        bus_write(2'd1, 32'h07);
        repeat (40) @(negedge clk);
        bus_write(2'd0, 32'hFF);
        bus_write(2'd1, 32'h07);
        @(negedge clk);
        address = 2'd1;
        done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!readdata[0]) begin
                done = 1;
                break;
            end
        end
        check("ign_done", {31'b0, done}, 32'd1);
        check("ign_sb_drained", exp_bits.size(), 0);
        check("ign_starts", starts, 1);
        check("ign_stops", stops, 1);
        push_byte(8'h96, 1'b0);
        run_cmd(8'h07, n, done);
        check("ign_txdata_kept_busy", n, 44 * DIV);
        check("ign_txdata_kept_sb", exp_bits.size(), 0);
        exp_bits.delete();

        // Reset mid-byte releases both lines immediately and clears status.
        chk_en = 0;
        bus_write(2'd0, 32'h5A);
        bus_write(2'd1, 32'h07);
        repeat (60) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_lines", {30'b0, scl_w, sda_w}, 32'd3);
        check("midrst_readdata", readdata, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        in_xfer = 0;
        exp_bits.delete();
        chk_en = 1;
        @(negedge clk);
        reset_n = 1'b1;
        read_reg(2'd1, rd);
        check("midrst_status", rd, 32'h0);
        run_vec(vecs[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
